if_id_inst_queue: RTL and testbench

//   Parametrised fetch->decode instruction queue replacing the single-entry IF/ID register.

---
 rtl/if_id_inst_queue_pkg.sv | 26 ++
 rtl/if_id_inst_queue.sv | 144 ++++++++++++++
 tb/tb_if_id_inst_queue.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_inst_queue_pkg.sv
// Shared definitions for the fetch->decode instruction queue: default
// geometry, the per-cycle queue action and small lane helpers.
package if_id_inst_queue_pkg;

  localparam int IQ_WORD   = 32;
  localparam int IQ_DEPTH  = 8;
  localparam int IQ_PUSH_W = 2;

  // What the queue does this cycle, decided from the stall/flush inputs.
  typedef enum logic [1:0] {
    IQ_RUN   = 2'd0,
    IQ_HOLD  = 2'd1,
    IQ_FLUSH = 2'd2
  } iq_action_e;

  // Number of lanes carrying an instruction (fetch is at most two lanes wide).
  function automatic logic [1:0] iqLaneCount(input logic [1:0] laneValid);
    return {1'b0, laneValid[0]} + {1'b0, laneValid[1]};
  endfunction

  // Lane valids must fill from lane 0 upward; a lone upper lane is malformed.
  function automatic logic iqLanesContiguous(input logic [1:0] laneValid);
    return laneValid != 2'b10;
  endfunction

endpackage

// File: rtl/if_id_inst_queue.sv
// Fetch->decode instruction queue. Fetch pushes up to PUSH_W {pc,inst}
// pairs per cycle, decode consumes one head entry per cycle. A DCache
// stall freezes everything, a load stall only holds the head, and a
// branch or ICache flush empties the queue.
module if_id_inst_queue
  import if_id_inst_queue_pkg::*;
#(
  parameter int WORD   = IQ_WORD,
  parameter int DEPTH  = IQ_DEPTH,
  parameter int PUSH_W = IQ_PUSH_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall_dcache,
  input  logic                       stall_load,
  input  logic                       flush_branch,
  input  logic                       flush_icache,
  input  logic [PUSH_W-1:0]          in_valid,
  input  logic [PUSH_W*WORD-1:0]     in_pc,
  input  logic [PUSH_W*WORD-1:0]     in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WORD-1:0]            out_pc,
  output logic [WORD-1:0]            out_inst,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(DEPTH - PUSH_W);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WORD-1:0] pc_q   [DEPTH];
  logic [WORD-1:0] inst_q [DEPTH];

  iq_action_e       action;
  logic             pop;
  logic             push;
  logic [1:0]       validPad;
  logic [1:0]       lanesWritten;
  logic [PUSH_W-1:0] laneWe;
  logic [PTR_W-1:0] laneAddr [PUSH_W];

  // Ready looks only at the registered count so stalls and pops never reach it combinationally.
  assign in_ready  = count_q <= READY_LIMIT;
  assign out_valid = count_q != '0;
  assign occupancy = count_q;

  // Freeze outranks flush, which outranks normal running.
  always_comb begin
    action = IQ_RUN;
    if (stall_dcache) begin
      action = IQ_HOLD;
    end else if (flush_branch || flush_icache) begin
      action = IQ_FLUSH;
    end
  end

  // Decide whether the head is consumed and how many fetch lanes are accepted.
  always_comb begin
    validPad             = '0;
    validPad[PUSH_W-1:0] = in_valid;
    pop                  = (action == IQ_RUN) && out_valid && !stall_load;
    push                 = (action == IQ_RUN) && in_ready;
    lanesWritten         = push ? iqLaneCount(validPad) : 2'd0;
  end

  // Next pointers and count; a flush discards any same-cycle push.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (action)
      IQ_FLUSH: begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
      IQ_RUN: begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(lanesWritten);
        count_d = count_q + CNT_W'(lanesWritten) - CNT_W'(pop);
      end
      default: begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
      end
    endcase
  end

  // Lane i lands at tail+i; pointer arithmetic wraps because DEPTH is a power of two.
  for (genvar g = 0; g < PUSH_W; g++) begin : gLane
    assign laneWe[g]   = push && in_valid[g];
    assign laneAddr[g] = tail_q + PTR_W'(g);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write port; contents are never cleared since the count masks stale slots.
  always_ff @(posedge clk) begin
    for (int l = 0; l < PUSH_W; l++) begin
      if (rst_n && laneWe[l]) begin
        pc_q[laneAddr[l]]   <= in_pc[l*WORD +: WORD];
        inst_q[laneAddr[l]] <= in_inst[l*WORD +: WORD];
      end
    end
  end

  // Head entry toward decode, forced to a zero bubble when the queue is empty.
  always_comb begin
    out_pc   = '0;
    out_inst = '0;
    if (out_valid) begin
      out_pc   = pc_q[head_q];
      out_inst = inst_q[head_q];
    end
  end

`ifndef SYNTHESIS
  // Fetch must never present a gap in its lane valids.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (iqLanesContiguous(validPad))
        else $error("if_id_inst_queue: non-contiguous in_valid %b", in_valid);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_inst_queue.sv
// Directed bench for the fetch->decode instruction queue (DEPTH 8, two lanes).
module tb_if_id_inst_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_dcache;
  logic        stall_load;
  logic        flush_branch;
  logic        flush_icache;
  logic [1:0]  in_valid;
  logic [63:0] in_pc;
  logic [63:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [3:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        sd;
    logic        sl;
    logic        fb;
    logic        fi;
    logic [1:0]  v;
    logic [31:0] base;
    logic        expOv;
    logic [31:0] expPc;
    logic [3:0]  expOcc;
    logic        expRdy;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];

  if_id_inst_queue #(.WORD(32), .DEPTH(8), .PUSH_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_dcache (stall_dcache),
    .stall_load   (stall_load),
    .flush_branch (flush_branch),
    .flush_icache (flush_icache),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .occupancy    (occupancy)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Instruction word that accompanies a given PC.
  function automatic logic [31:0] instOf(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h0000_0013;
  endfunction

  function automatic void addVec(input logic sd, input logic sl, input logic fb, input logic fi,
                                 input logic [1:0] v, input logic [31:0] base,
                                 input logic expOv, input logic [31:0] expPc,
                                 input logic [3:0] expOcc, input logic expRdy);
    vec_t r;
    r.sd = sd; r.sl = sl; r.fb = fb; r.fi = fi; r.v = v; r.base = base;
    r.expOv = expOv; r.expPc = expPc; r.expOcc = expOcc; r.expRdy = expRdy;
    vecs.push_back(r);
  endfunction

  task automatic applyStimulus(input logic sd, input logic sl, input logic fb, input logic fi,
                               input logic [1:0] v, input logic [31:0] base);
    stall_dcache = sd;
    stall_load   = sl;
    flush_branch = fb;
    flush_icache = fi;
    in_valid     = v;
    in_pc        = {base + 32'd4, base};
    in_inst      = {instOf(base + 32'd4), instOf(base)};
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic expOv, input logic [31:0] expPc,
                             input logic [3:0] expOcc, input logic expRdy);
    checkOne({name, "/out_valid"}, 32'(out_valid), 32'(expOv));
    checkOne({name, "/out_pc"}, out_pc, expOv ? expPc : 32'd0);
    checkOne({name, "/out_inst"}, out_inst, expOv ? instOf(expPc) : 32'd0);
    checkOne({name, "/occupancy"}, 32'(occupancy), 32'(expOcc));
    checkOne({name, "/in_ready"}, 32'(in_ready), 32'(expRdy));
  endtask

  task automatic doReset(input string name);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 32'h1c00_0000);
    stepCycle();
    stepCycle();
    checkOutput(name, 1'b0, 32'd0, 4'd0, 1'b1);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
  endtask

  // Hang guard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] nextPc;
    logic        accept;

    // Reset with both lanes valid must leave the queue empty.
    doReset("reset");

    // sd sl fb fi v base | ov pc occ rdy
    addVec(0,1,0,0,2'b11,32'h1c000000, 1,32'h1c000000,4'd2,1);
    addVec(0,1,0,0,2'b00,32'h0,        1,32'h1c000000,4'd2,1);
    addVec(0,0,0,0,2'b00,32'h0,        1,32'h1c000004,4'd1,1);
    addVec(0,0,0,0,2'b00,32'h0,        0,32'h0,       4'd0,1);
    addVec(0,1,0,0,2'b11,32'h1c000100, 1,32'h1c000100,4'd2,1);
    addVec(0,1,0,0,2'b11,32'h1c000108, 1,32'h1c000100,4'd4,1);
    addVec(0,1,0,0,2'b01,32'h1c000110, 1,32'h1c000100,4'd5,1);
    addVec(0,1,1,0,2'b11,32'h1c000200, 0,32'h0,       4'd0,1);
    addVec(0,1,0,0,2'b11,32'h1c000300, 1,32'h1c000300,4'd2,1);
    addVec(0,1,0,0,2'b11,32'h1c000308, 1,32'h1c000300,4'd4,1);
    addVec(0,1,0,0,2'b01,32'h1c000310, 1,32'h1c000300,4'd5,1);
    addVec(0,1,0,1,2'b11,32'h1c000380, 0,32'h0,       4'd0,1);
    addVec(0,1,0,0,2'b11,32'h1c000400, 1,32'h1c000400,4'd2,1);
    addVec(0,1,0,0,2'b01,32'h1c000408, 1,32'h1c000400,4'd3,1);
    addVec(1,0,1,0,2'b11,32'h1c000480, 1,32'h1c000400,4'd3,1);
    addVec(1,0,1,0,2'b11,32'h1c000480, 1,32'h1c000400,4'd3,1);
    addVec(0,0,1,0,2'b11,32'h1c000480, 0,32'h0,       4'd0,1);
    addVec(0,1,0,0,2'b11,32'h1c000500, 1,32'h1c000500,4'd2,1);
    addVec(1,0,0,0,2'b11,32'h1c000600, 1,32'h1c000500,4'd2,1);
    addVec(0,0,0,0,2'b00,32'h0,        1,32'h1c000504,4'd1,1);
    addVec(0,0,0,0,2'b11,32'h1c000700, 1,32'h1c000700,4'd2,1);
    addVec(0,0,0,0,2'b00,32'h0,        1,32'h1c000704,4'd1,1);
    addVec(0,0,0,0,2'b00,32'h0,        0,32'h0,       4'd0,1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].sd, vecs[i].sl, vecs[i].fb, vecs[i].fi, vecs[i].v, vecs[i].base);
      stepCycle();
      checkOutput($sformatf("vec%0d", i), vecs[i].expOv, vecs[i].expPc, vecs[i].expOcc, vecs[i].expRdy);
    end

    // Fill to full while decode is stalled, then alternate pop/push across the wrap.
    doReset("fill_reset");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 32'h1c001000 + 32'(8 * k));
      stepCycle();
      checkOutput($sformatf("fill%0d", k), 1'b1, 32'h1c001000, 4'(2 * k + 2), 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 32'h1c001018);
    stepCycle();
    checkOutput("fill_full", 1'b1, 32'h1c001000, 4'd8, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 32'h1c002000);
    stepCycle();
    checkOutput("full_push_blocked", 1'b1, 32'h1c001000, 4'd8, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    stepCycle();
    checkOutput("seven_left", 1'b1, 32'h1c001004, 4'd7, 1'b0);

    sb.delete();
    for (int k = 1; k < 8; k++) sb.push_back(32'h1c001000 + 32'(4 * k));
    nextPc = 32'h1c001020;
    for (int c = 0; c < 20; c++) begin
      accept = sb.size() <= 6;
      checkOne($sformatf("alt%0d/in_ready_pre", c), 32'(in_ready), 32'(accept));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, nextPc);
      if (accept) begin
        sb.push_back(nextPc);
        sb.push_back(nextPc + 32'd4);
        nextPc = nextPc + 32'd8;
      end
      void'(sb.pop_front());
      stepCycle();
      checkOutput($sformatf("alt%0d", c), 1'b1, sb[0], 4'(sb.size()), sb.size() <= 6);
    end
    for (int d = 0; d < 10 && sb.size() > 0; d++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
      void'(sb.pop_front());
      stepCycle();
      if (sb.size() > 0) checkOutput($sformatf("drain%0d", d), 1'b1, sb[0], 4'(sb.size()), sb.size() <= 6);
      else checkOutput($sformatf("drain%0d", d), 1'b0, 32'h0, 4'd0, 1'b1);
    end

    // Park tail at slot 7, then a single-lane push followed by a wrapping dual push.
    doReset("wrap_reset");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 32'h1c003000 + 32'(8 * k));
      stepCycle();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h1c003018);
    stepCycle();
    checkOutput("tail7_fill", 1'b1, 32'h1c003000, 4'd7, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
      stepCycle();
      if (i < 7) checkOutput($sformatf("tail7_pop%0d", i), 1'b1, 32'h1c003000 + 32'(4 * i), 4'(7 - i), 4'(7 - i) <= 4'd6);
      else checkOutput("tail7_empty", 1'b0, 32'h0, 4'd0, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h1c004000);
    stepCycle();
    checkOutput("slot7_push", 1'b1, 32'h1c004000, 4'd1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 32'h1c004100);
    stepCycle();
    checkOutput("wrap_push", 1'b1, 32'h1c004000, 4'd3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    stepCycle();
    checkOutput("wrap_pop0", 1'b1, 32'h1c004100, 4'd2, 1'b1);
    stepCycle();
    checkOutput("wrap_pop1", 1'b1, 32'h1c004104, 4'd1, 1'b1);
    stepCycle();
    checkOutput("wrap_pop2", 1'b0, 32'h0, 4'd0, 1'b1);

    // Reset arriving with a non-empty queue still wins.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 32'h1c005000);
    stepCycle();
    doReset("late_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
